// File: rtl/soc_pio_irq.sv
// Avalon-MM parallel I/O port with per-bit output enable, input synchroniser,
// edge capture, interrupt mask and atomic bit-set/bit-clear writes.
module soc_pio_irq #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_OUT = RESET_VALUE[WIDTH-1:0];

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] capture_clr;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_in   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync_in;
    end
  end

  always_comb begin
    edge_vec = sync_in ^ sync_d;
    if (EDGE_TYPE == 0)      edge_vec = sync_in & ~sync_d;
    else if (EDGE_TYPE == 1) edge_vec = ~sync_in & sync_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RST_OUT;
      out_oe   <= '0;
      mask     <= '0;
    end else if (wr_en) begin
      case (address)
        3'd0:    out_port <= wd;
        3'd1:    out_oe   <= wd;
        3'd2:    mask     <= wd;
        3'd4:    out_port <= out_port | wd;
        3'd5:    out_port <= out_port & ~wd;
        default: ;
      endcase
    end
  end

  // A fresh edge is OR-ed in after the clear so a same-cycle set wins.
  assign capture_clr = (wr_en && address == 3'd3) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~capture_clr) | edge_vec;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = sync_in;
      3'd1:    rd_mux[WIDTH-1:0] = out_oe;
      3'd2:    rd_mux[WIDTH-1:0] = mask;
      3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  // Both sources are flop outputs, so irq has no path from the bus pins.
  assign irq = (IRQ_TYPE == 0) ? |(sync_in & mask) : |(edge_capture & mask);

endmodule

// File: doc/soc_pio_irq.md
Name: soc_pio_irq

Overview:
Parametrised Avalon-MM parallel I/O port: the next generation of the SoC's PIO slaves (e.g. the OTG HPI data port). Adds per-bit output-enable, an input synchroniser, edge capture, an interrupt mask and an IRQ line, plus atomic bit-set and bit-clear writes. It sits between the Avalon interconnect and external pins or peripherals such as the USB OTG HPI bus.

Parameters:
WIDTH, 16, port width in bits, 1..32.
RESET_VALUE, 0, reset value of the output data register; only the low WIDTH bits are used.
EDGE_TYPE, 0, edge detect select: 0 = rising, 1 = falling, 2 = any.
IRQ_TYPE, 0, interrupt source: 0 = level (synchronised input), 1 = edge (edge-capture register).
SYNC_STAGES, 2, input synchroniser depth, 2..3.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  external input pins, asynchronous to clk
out_port  out  WIDTH  output data register
out_oe  out  WIDTH  per-bit output enable (direction register)
readdata  out  32  registered read data
irq  out  1  interrupt request, active high

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
  - On reset: out_port = RESET_VALUE[WIDTH-1:0]; out_oe = 0; mask = 0; edge_capture = 0; readdata = 0; synchroniser and delay flops = 0; irq = 0.
  - Reset mid-operation clears all of these immediately. Any edge in flight is lost.
- Register map (addr: read / write):
  - 0: synchronised input / out_port <= wd.
  - 1: out_oe / out_oe <= wd.
  - 2: mask / mask <= wd.
  - 3: edge_capture / write-1-to-clear.
  - 4: 0 / out_port <= out_port | wd (set bits).
  - 5: 0 / out_port <= out_port & ~wd (clear bits).
  - 6, 7: read 0; writes ignored.
- Width rules:
  - "wd" means writedata[WIDTH-1:0]; writedata bits at and above WIDTH are ignored.
  - readdata bits at and above WIDTH always read 0.
- Writes:
  - A write occurs when chipselect && !write_n.
  - It takes effect on the next clk edge. No wait states.
- Reads:
  - readdata is registered every cycle from the address mux, independent of chipselect.
  - Read latency is 1 cycle.
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in, then one further delay flop to give sync_d.
  - Edge vector:
    - rising = sync_in & ~sync_d
    - falling = ~sync_in & sync_d
    - any = sync_in ^ sync_d
  - An input change settling before clk edge 1 appears in sync_in after edge SYNC_STAGES and can be read at address 0 one cycle later.
- Edge capture:
  - A bit is set at the clk edge after its edge-vector bit is asserted, i.e. after edge SYNC_STAGES+1.
  - Bits are sticky until cleared.
  - A simultaneous detected edge and write-1-to-clear on the same bit: set wins, and the bit stays 1.
- IRQ:
  - IRQ_TYPE 0: irq = |(sync_in & mask).
  - IRQ_TYPE 1: irq = |(edge_capture & mask).
  - irq is derived only from flops; there is no combinational path from bus inputs.
  - Masking a pending bit deasserts irq on the cycle after the mask write.
- out_port and out_oe are plain register outputs. Tristating is done outside the block, per bit, using out_oe.

Test Plan:
- Reset/defaults (WIDTH=16, RESET_VALUE=16'hA5A5): assert reset_n=0 mid-run -> out_port=A5A5, out_oe=0, irq=0, readdata=0 immediately; read addr 1, 2, 3 -> 0.
- Set/clear: write addr0=16'h00F0, addr4=16'h0F01, addr5=16'h0081 -> out_port=0F70; write addr0=32'hFFFF1234 -> out_port=1234; read addr0 upper readdata bits = 0.
- Sync latency (SYNC_STAGES=2): drive in_port 0->16'h0003 before edge 1, hold address=0 -> readdata=0003 after edge 3, not earlier.
- Edge capture (EDGE_TYPE=0, IRQ_TYPE=1, mask=16'h0001): rising edge on bit0 -> edge_capture=0001 after edge 3, irq=1; falling edge -> no change; write addr3=1 -> capture=0, irq=0 next cycle.
- Simultaneous: a rising edge on bit2 detected in the same cycle as a write addr3=16'h0004 -> bit2 remains 1.
- Level IRQ (IRQ_TYPE=0, mask=16'h8000): in_port[15]=1 -> irq=1 after sync latency; write mask=0 -> irq=0 next cycle; EDGE_TYPE=2 toggle bit3 twice -> capture bit3=1.
